// File: rtl/sevseg_scan_decoder.sv
// Loopback monitor for a multiplexed seven-segment display: waits for each
// anode dwell to settle, decodes the cathode glyph and assembles the digits.
module sevseg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIGITS-1:0]     an,
    input  logic [6:0]                ca,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     invalid,
    output logic                      frame_done
);

    localparam int unsigned CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]    BLANK   = 7'h7F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DWELL    = 2'd1,
        CAPTURED = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [NUM_DIGITS-1:0]     s_an_q, s_an_d;
    logic [6:0]                s_ca_q, s_ca_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]     seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0]   value_q, value_d;
    logic [NUM_DIGITS-1:0]     digit_valid_q, digit_valid_d;
    logic [NUM_DIGITS-1:0]     invalid_q, invalid_d;
    logic                      frame_done_q, frame_done_d;

    logic                      changed_c;
    logic                      an_one_hot_c;
    logic                      capture_c;
    logic [NUM_DIGITS-1:0]     sel_c;
    logic [NUM_DIGITS-1:0]     seen_all_c;
    logic                      glyph_hit_c;
    logic [3:0]                glyph_nib_c;

    // Cathode glyph -> {hit, nibble}; bit order {CA..CG}, active-low.
    function automatic logic [4:0] decode_glyph(input logic [6:0] c);
        logic [4:0] r;
        unique case (c)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    assign changed_c    = (an != s_an_q) || (ca != s_ca_q);
    assign an_one_hot_c = ($countones(~an) == 1);
    assign capture_c    = (state_q == DWELL) && !changed_c && (cnt_q == CNT_MAX);
    assign sel_c        = ~s_an_q;
    assign seen_all_c   = seen_q | sel_c;
    assign {glyph_hit_c, glyph_nib_c} = decode_glyph(s_ca_q);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            s_an_q        <= '1;
            s_ca_q        <= BLANK;
            cnt_q         <= '0;
            seen_q        <= '0;
            value_q       <= '0;
            digit_valid_q <= '0;
            invalid_q     <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_an_q        <= s_an_d;
            s_ca_q        <= s_ca_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            value_q       <= value_d;
            digit_valid_q <= digit_valid_d;
            invalid_q     <= invalid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, CAPTURED: begin
                if (changed_c) state_d = an_one_hot_c ? DWELL : IDLE;
            end
            DWELL: begin
                if (changed_c)              state_d = an_one_hot_c ? DWELL : IDLE;
                else if (cnt_q == CNT_MAX)  state_d = CAPTURED;
            end
            default: state_d = IDLE;
        endcase
    end

    // Input sampling, dwell counter and capture outputs.
    always_comb begin
        s_an_d        = an;
        s_ca_d        = ca;
        cnt_d         = cnt_q;
        seen_d        = seen_q;
        value_d       = value_q;
        digit_valid_d = digit_valid_q;
        invalid_d     = invalid_q;
        frame_done_d  = 1'b0;

        if (changed_c)             cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);

        if (capture_c) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (sel_c[i]) begin
                    if (glyph_hit_c) begin
                        value_d[4*i +: 4] = glyph_nib_c;
                        digit_valid_d[i]  = 1'b1;
                        invalid_d[i]      = 1'b0;
                    end else begin
                        digit_valid_d[i]  = 1'b0;
                        invalid_d[i]      = (s_ca_q != BLANK);
                    end
                end
            end
            if (&seen_all_c) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d       = seen_all_c;
            end
        end
    end

    assign value       = value_q;
    assign digit_valid = digit_valid_q;
    assign invalid     = invalid_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Self-checking bench for sevseg_scan_decoder: directed scenarios plus
// randomized scan traffic against a run-length reference model.
module tb_sevseg_scan_decoder;

    localparam int S = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  ca;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [3:0]  invalid;
    logic        frame_done;

    sevseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .ca(ca),
        .value(value), .digit_valid(digit_valid), .invalid(invalid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int dut_pulses, mdl_pulses, pulse_cyc;

    // Reference model state: how long the pins have been identical.
    logic [15:0] m_val;
    logic [3:0]  m_dv, m_inv, m_seen, p_an;
    logic [6:0]  p_ca;
    logic        m_fd, m_done;
    int          run;

    function automatic void model_step(input logic r, input logic [3:0] a, input logic [6:0] c);
        int idx, hit, nib;
        if (!r) begin
            m_val = 0; m_dv = 0; m_inv = 0; m_fd = 0; m_seen = 0;
            p_an = 4'hF; p_ca = 7'h7F; run = 0; m_done = 0;
            return;
        end
        m_fd = 0;
        if (a != p_an || c != p_ca) begin
            p_an = a; p_ca = c; run = 0; m_done = 0;
            return;
        end
        run++;
        if (run >= S && !m_done && $countones(~a) == 1) begin
            m_done = 1;
            idx = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
            hit = 0; nib = 0;
            for (int g = 0; g < 16; g++) if (glyph[g] == c) begin hit = 1; nib = g; end
            if (hit != 0) begin
                m_val[4*idx +: 4] = 4'(nib); m_dv[idx] = 1; m_inv[idx] = 0;
            end else begin
                m_dv[idx] = 0; m_inv[idx] = (c != 7'h7F);
            end
            m_seen[idx] = 1;
            if (m_seen == 4'hF) begin m_fd = 1; m_seen = 0; end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(rst_n, an, ca);
        cyc++;
        #1;
        if (frame_done) begin dut_pulses++; pulse_cyc = cyc; end
        if (m_fd) mdl_pulses++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] c, input int n);
        an = a; ca = c;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst_n = 0; tick(); rst_n = 1;
        dut_pulses = 0; mdl_pulses = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            an = 4'($urandom); ca = 7'($urandom); tick();
        end
        nvec++;
        if ({value, digit_valid, invalid, frame_done} !== 25'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got value=%h dv=%b inv=%b fd=%b, want all zero",
                     value, digit_valid, invalid, frame_done);
        end
        rst_n = 1;
        dut_pulses = 0; mdl_pulses = 0;
        hold(4'b1110, glyph[3], S);
        nvec++;
        if (digit_valid !== 4'b0000 || value !== 16'h0) begin
            nerr++;
            $display("FAIL reset_no_early_capture: got dv=%b value=%h, want 0000/0000", digit_valid, value);
        end
    endtask

    task automatic test_single_capture();
        do_reset();
        hold(4'b1110, 7'b0000110, S);
        nvec++;
        if (value[3:0] !== 4'h0 || digit_valid !== 4'b0000) begin
            nerr++;
            $display("FAIL single_edge15: got nib=%h dv=%b, want 0/0000", value[3:0], digit_valid);
        end
        hold(4'b1110, 7'b0000110, 1);
        nvec++;
        if (value[3:0] !== 4'h3 || digit_valid !== 4'b0001) begin
            nerr++;
            $display("FAIL single_edge16: got nib=%h dv=%b, want 3/0001", value[3:0], digit_valid);
        end
        hold(4'b1110, 7'b0000110, 3);
        nvec++;
        if (dut_pulses !== 0) begin
            nerr++;
            $display("FAIL single_no_frame: got %0d pulses, want 0", dut_pulses);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        hold(4'b1101, 7'b0000110, 10);
        hold(4'b1101, 7'b0010010, S);
        nvec++;
        if (value[7:4] !== 4'h0 || digit_valid !== 4'b0000) begin
            nerr++;
            $display("FAIL glitch_before: got nib=%h dv=%b, want 0/0000", value[7:4], digit_valid);
        end
        hold(4'b1101, 7'b0010010, 1);
        nvec++;
        if (value[7:4] !== 4'h2 || digit_valid !== 4'b0010) begin
            nerr++;
            $display("FAIL glitch_capture: got nib=%h dv=%b, want 2/0010", value[7:4], digit_valid);
        end
        hold(4'b1101, 7'b0010010, 3);
    endtask

    task automatic test_full_frame();
        logic [6:0] g [4];
        int start3;
        g[0] = glyph[1]; g[1] = glyph[10]; g[2] = glyph[11]; g[3] = glyph[15];
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            dut_pulses = 0; pulse_cyc = -1; start3 = 0;
            for (int d = 0; d < 4; d++) begin
                if (d == 3) start3 = cyc + 1;
                hold(~(4'b0001 << d), g[d], 32);
            end
            nvec++;
            if (value !== 16'hFBA1 || digit_valid !== 4'hF || invalid !== 4'h0) begin
                nerr++;
                $display("FAIL frame_value pass%0d: got %h dv=%b inv=%b, want FBA1/1111/0000",
                         pass, value, digit_valid, invalid);
            end
            nvec++;
            if (dut_pulses !== 1 || pulse_cyc !== start3 + S) begin
                nerr++;
                $display("FAIL frame_pulse pass%0d: got %0d pulses at cycle %0d, want 1 at %0d",
                         pass, dut_pulses, pulse_cyc, start3 + S);
            end
        end
    endtask

    task automatic test_blank_invalid();
        logic [24:0] snap;
        hold(4'b1101, 7'b1111110, 32);
        nvec++;
        if (invalid !== 4'b0010 || digit_valid !== 4'b1101 || value !== 16'hFBA1) begin
            nerr++;
            $display("FAIL invalid_glyph: got inv=%b dv=%b value=%h, want 0010/1101/FBA1",
                     invalid, digit_valid, value);
        end
        hold(4'b1101, 7'b1111111, 32);
        nvec++;
        if (invalid !== 4'b0000 || digit_valid !== 4'b1101 || value !== 16'hFBA1) begin
            nerr++;
            $display("FAIL blank_glyph: got inv=%b dv=%b value=%h, want 0000/1101/FBA1",
                     invalid, digit_valid, value);
        end
        snap = {value, digit_valid, invalid, frame_done};
        dut_pulses = 0;
        hold(4'b1100, glyph[8], 40);
        nvec++;
        if ({value, digit_valid, invalid, frame_done} !== snap || dut_pulses !== 0) begin
            nerr++;
            $display("FAIL multi_anode: got %h pulses=%0d, want %h pulses=0",
                     {value, digit_valid, invalid, frame_done}, dut_pulses, snap);
        end
    endtask

    task automatic test_reset_mid_dwell();
        do_reset();
        hold(4'b1011, glyph[5], 9);
        rst_n = 0; tick(); rst_n = 1;
        hold(4'b1011, glyph[5], S);
        nvec++;
        if (digit_valid !== 4'b0000 || value !== 16'h0) begin
            nerr++;
            $display("FAIL mid_reset_discard: got dv=%b value=%h, want 0000/0000", digit_valid, value);
        end
        hold(4'b1011, glyph[5], 1);
        nvec++;
        if (value[11:8] !== 4'h5 || digit_valid !== 4'b0100) begin
            nerr++;
            $display("FAIL mid_reset_capture: got nib=%h dv=%b, want 5/0100", value[11:8], digit_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] c;
        int n, sel;
        do_reset();
        for (int burst = 0; burst < 150; burst++) begin
            sel = int'($urandom_range(0, 9));
            a = (sel < 7) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            sel = int'($urandom_range(0, 9));
            c = (sel < 7) ? glyph[$urandom_range(0, 15)] : (sel < 9 ? 7'h7F : 7'($urandom));
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(S - 2, S + 8));
            rst_n = ($urandom_range(0, 60) != 0);
            an = a; ca = c;
            for (int k = 0; k < n; k++) begin
                tick();
                rst_n = 1;
                nvec++;
                if ({value, digit_valid, invalid, frame_done} !== {m_val, m_dv, m_inv, m_fd}) begin
                    nerr++;
                    $display("FAIL random cyc%0d: got v=%h dv=%b inv=%b fd=%b, want v=%h dv=%b inv=%b fd=%b",
                             cyc, value, digit_valid, invalid, frame_done, m_val, m_dv, m_inv, m_fd);
                end
            end
        end
    endtask

    initial begin
        rst_n = 0; an = 4'hF; ca = 7'h7F;
        dut_pulses = 0; mdl_pulses = 0; pulse_cyc = -1;
        test_reset();
        test_single_capture();
        test_glitch();
        test_full_frame();
        test_blank_invalid();
        test_reset_mid_dwell();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
